// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: serialises OSD requests (disable, enable, info window, line write) onto the io_osd/io_strobe/io_din command port
//
// Build option: define OSD_TX_FILL_EN to make op 4 (fill a line with one constant byte) legal.
// Without it, op 4 is rejected like ops 5-7.
//
// Ports
//   i_clk_sys, i_reset           clock, synchronous active-high reset
//   i_req_valid, o_req_ready     request handshake; ready only while IDLE
//   i_req_op                     0=disable 1=enable 2=info 3=write 4=fill 5-7 illegal
//   i_req_line                   write/fill line index (bit3 selects the highres half)
//   i_req_x, i_req_y             info window position (pixels, lines)
//   i_req_w, i_req_h             info window size (8-pixel, 8-line units)
//   i_req_fill                   fill byte
//   o_rd_en, o_rd_addr           byte-source read; i_rd_data is valid one cycle after o_rd_en
//   o_req_err                    one-cycle pulse when an illegal op is accepted
//   o_busy                       high from acceptance until the return to IDLE
//   o_io_osd, o_io_strobe        frame select and word strobe to the OSD block
//   o_io_din                     command/data word
module osd_cmd_tx #(
    parameter int STROBE_HI  = 2,
    parameter int STROBE_LO  = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [4:0]  i_req_line,
    input  logic [11:0] i_req_x,
    input  logic [11:0] i_req_y,
    input  logic [5:0]  i_req_w,
    input  logic [5:0]  i_req_h,
    input  logic [7:0]  i_req_fill,
    output logic        o_rd_en,
    output logic [7:0]  o_rd_addr,
    input  logic [7:0]  i_rd_data,
    output logic        o_req_err,
    output logic        o_busy,
    output logic        o_io_osd,
    output logic        o_io_strobe,
    output logic [15:0] o_io_din
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SETUP, S_HI, S_LO, S_GAP
    } state_t;

    localparam logic [15:0] HI_LD  = 16'(STROBE_HI - 1);
    localparam logic [15:0] LO_LD  = 16'(STROBE_LO - 1);
    localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES - 1);

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [8:0]  r_col, w_col, w_col_n;
    logic        r_cmd, w_cmd;
    logic [2:0]  r_op, w_op;
    logic [11:0] r_x, w_x, r_y, w_y;
    logic [5:0]  r_w, w_w, r_h, w_h;
    logic        r_osd, w_osd;
    logic        r_strobe, w_strobe;
    logic [15:0] r_din, w_din;
    logic        r_rd_en, w_rd_en;
    logic [7:0]  r_rd_addr, w_rd_addr;
    logic        r_err, w_err;
    logic [15:0] w_cmd_word, w_info_word, w_fill_word;
    logic        w_legal, w_done, w_fetch;

`ifdef OSD_TX_FILL_EN
    logic [7:0] r_fill;

    always_ff @(posedge i_clk_sys) begin
        if (r_state == S_IDLE && i_req_valid)
            r_fill <= i_req_fill;
    end

    assign w_legal     = i_req_op <= 3'd4;
    // Fill words come from the captured byte, so only the write op reads the byte source.
    assign w_fetch     = r_op == 3'd3;
    assign w_fill_word = {8'h00, r_fill};
`else
    logic w_unused_fill;

    assign w_unused_fill = ^i_req_fill;
    assign w_legal       = i_req_op <= 3'd3;
    assign w_fetch       = 1'b1;
    assign w_fill_word   = 16'h0000;
`endif

    assign w_cmd_word  = i_req_op == 3'd0 ? 16'h0040 :
                         i_req_op == 3'd1 ? 16'h0041 :
                         i_req_op == 3'd2 ? 16'h0045 : {8'h00, 3'b001, i_req_line};
    // Index of the data word that follows the one just finished; the command word is followed by word 0.
    assign w_col_n     = r_cmd ? 9'd0 : r_col + 9'd1;
    assign w_info_word = w_col_n[1:0] == 2'd0 ? {4'h0, r_x} :
                         w_col_n[1:0] == 2'd1 ? {4'h0, r_y} :
                         w_col_n[1:0] == 2'd2 ? {10'h000, r_w} : {10'h000, r_h};
    // Line frames end when the 9-bit column reaches 256.
    assign w_done      = r_op <= 3'd1 || (r_op == 3'd2 ? w_col_n == 9'd4 : w_col_n[8]);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_col     = r_col;
        w_cmd     = r_cmd;
        w_op      = r_op;
        w_x       = r_x;
        w_y       = r_y;
        w_w       = r_w;
        w_h       = r_h;
        w_osd     = r_osd;
        w_strobe  = r_strobe;
        w_din     = r_din;
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_addr;
        w_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid && w_legal) begin
                    w_state = S_SETUP;
                    w_cmd   = 1'b1;
                    w_col   = '0;
                    w_op    = i_req_op;
                    w_x     = i_req_x;
                    w_y     = i_req_y;
                    w_w     = i_req_w;
                    w_h     = i_req_h;
                    w_osd   = 1'b1;
                    w_din   = w_cmd_word;
                end else if (i_req_valid) begin
                    w_err = 1'b1;
                end
            end
            S_FETCH: w_state = S_LATCH;
            S_LATCH: begin
                w_state = S_SETUP;
                w_din   = {8'h00, i_rd_data};
            end
            S_SETUP: begin
                w_state  = S_HI;
                w_cnt    = HI_LD;
                w_strobe = 1'b1;
            end
            S_HI: begin
                if (r_cnt == '0) begin
                    w_state  = S_LO;
                    w_cnt    = LO_LD;
                    w_strobe = 1'b0;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            S_LO: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 16'd1;
                end else if (w_done) begin
                    w_state = S_GAP;
                    w_cnt   = GAP_LD;
                    w_osd   = 1'b0;
                end else begin
                    w_cmd = 1'b0;
                    w_col = w_col_n;
                    if (r_op == 3'd2 || !w_fetch) begin
                        w_state = S_SETUP;
                        w_din   = r_op == 3'd2 ? w_info_word : w_fill_word;
                    end else begin
                        w_state   = S_FETCH;
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_col_n[7:0];
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == '0)
                    w_state = S_IDLE;
                else
                    w_cnt = r_cnt - 16'd1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_col     <= '0;
            r_cmd     <= 1'b0;
            r_op      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_osd     <= 1'b0;
            r_strobe  <= 1'b0;
            r_din     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_col     <= w_col;
            r_cmd     <= w_cmd;
            r_op      <= w_op;
            r_x       <= w_x;
            r_y       <= w_y;
            r_w       <= w_w;
            r_h       <= w_h;
            r_osd     <= w_osd;
            r_strobe  <= w_strobe;
            r_din     <= w_din;
            r_rd_en   <= w_rd_en;
            r_rd_addr <= w_rd_addr;
            r_err     <= w_err;
        end
    end

    assign o_req_ready = r_state == S_IDLE && !i_reset;
    assign o_busy      = r_state != S_IDLE;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_req_err   = r_err;
    assign o_io_osd    = r_osd;
    assign o_io_strobe = r_strobe;
    assign o_io_din    = r_din;
endmodule
